// File: rtl/sb_cfg_loader.sv
// Switch-box configuration loader: shifts bus words into a shadow image and commits it atomically to cfg_out.
// Optional odd-parity checking of incoming words is enabled with `define SB_CFG_PARITY_EN.
module sb_cfg_loader #(
  parameter int CFG_SIZE   = 256,
  parameter int WORD_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cfg_start,
  input  logic                  cfg_in_valid,
  output logic                  cfg_in_ready,
  input  logic [WORD_WIDTH-1:0] cfg_in_data,
`ifdef SB_CFG_PARITY_EN
  input  logic                  cfg_in_parity,
`endif
  output logic [CFG_SIZE-1:0]   cfg_out,
  output logic                  cfg_busy,
  output logic                  cfg_done
`ifdef SB_CFG_PARITY_EN
  ,
  output logic                  cfg_err
`endif
);

  localparam int NUM_WORDS = CFG_SIZE / WORD_WIDTH;
  localparam int CNT_W     = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_WORDS - 1);

  typedef enum logic [1:0] {IDLE, LOAD, COMMIT} state_t;

  state_t              state;
  state_t              state_next;
  logic [CNT_W-1:0]    cnt;
  logic [CFG_SIZE-1:0] shadow;
  logic [CFG_SIZE-1:0] shadow_shift;
  logic                handshake;
  logic                bad_word;
  logic                accept;

  assign handshake = cfg_in_valid & cfg_in_ready;

`ifdef SB_CFG_PARITY_EN
  assign bad_word = handshake & ~(^{cfg_in_data, cfg_in_parity});
`else
  assign bad_word = 1'b0;
`endif

  assign accept = handshake & ~bad_word;

  // New words enter at the top so word k settles at bits [k*WORD_WIDTH +: WORD_WIDTH].
  if (NUM_WORDS > 1) begin : g_shift
    assign shadow_shift = {cfg_in_data, shadow[CFG_SIZE-1:WORD_WIDTH]};
  end else begin : g_single
    assign shadow_shift = cfg_in_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next   = state;
    cfg_in_ready = 1'b0;
    cfg_busy     = 1'b0;
    case (state)
      IDLE: begin
        if (cfg_start) begin
          state_next = LOAD;
        end
      end
      LOAD: begin
        cfg_in_ready = 1'b1;
        cfg_busy     = 1'b1;
        if (bad_word) begin
          state_next = IDLE;
        end else if (accept && (cnt == LAST_CNT)) begin
          state_next = COMMIT;
        end
      end
      COMMIT: begin
        cfg_busy   = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt      <= '0;
      shadow   <= '0;
      cfg_out  <= '0;
      cfg_done <= 1'b0;
    end else begin
      cfg_done <= (state == COMMIT);
      if (state == COMMIT) begin
        cfg_out <= shadow;
      end
      if ((state == IDLE) && cfg_start) begin
        cnt <= '0;
      end else if (accept) begin
        shadow <= shadow_shift;
        cnt    <= cnt + CNT_W'(1);
      end
    end
  end

`ifdef SB_CFG_PARITY_EN
  // Sticky until the next accepted start, so software can see why a load was abandoned.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cfg_err <= 1'b0;
    end else if ((state == IDLE) && cfg_start) begin
      cfg_err <= 1'b0;
    end else if (bad_word) begin
      cfg_err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_sb_cfg_loader.sv
// Self-checking bench for sb_cfg_loader: directed loads with a scoreboard of expected committed images.
// Build with +define+SB_CFG_PARITY_EN to include the parity-error scenario.
module tb_sb_cfg_loader;

  localparam int CFG_SIZE   = 256;
  localparam int WORD_WIDTH = 32;
  localparam int NUM_WORDS  = CFG_SIZE / WORD_WIDTH;

  logic                  clk;
  logic                  rst;
  logic                  cfg_start;
  logic                  cfg_in_valid;
  logic                  cfg_in_ready;
  logic [WORD_WIDTH-1:0] cfg_in_data;
  logic [CFG_SIZE-1:0]   cfg_out;
  logic                  cfg_busy;
  logic                  cfg_done;
`ifdef SB_CFG_PARITY_EN
  logic                  cfg_in_parity;
  logic                  cfg_err;
`endif

  int checks = 0;
  int errors = 0;
  int busy_cycles = 0;
  int done_count = 0;
  int exp_commits = 0;

  logic [CFG_SIZE-1:0] expq[$];
  logic [CFG_SIZE-1:0] img_a, img_b, img_x, img_y;

  sb_cfg_loader #(.CFG_SIZE(CFG_SIZE), .WORD_WIDTH(WORD_WIDTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .cfg_start    (cfg_start),
    .cfg_in_valid (cfg_in_valid),
    .cfg_in_ready (cfg_in_ready),
    .cfg_in_data  (cfg_in_data),
`ifdef SB_CFG_PARITY_EN
    .cfg_in_parity(cfg_in_parity),
`endif
    .cfg_out      (cfg_out),
    .cfg_busy     (cfg_busy),
    .cfg_done     (cfg_done)
`ifdef SB_CFG_PARITY_EN
    ,
    .cfg_err      (cfg_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [CFG_SIZE-1:0] obs,
                             input logic [CFG_SIZE-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Inputs are changed 1ns after a rising edge, then one rising edge is consumed.
  task automatic applyStimulus(input logic start, input logic valid,
                               input logic [WORD_WIDTH-1:0] data, input logic bad);
    cfg_start    = start;
    cfg_in_valid = valid;
    cfg_in_data  = data;
`ifdef SB_CFG_PARITY_EN
    cfg_in_parity = bad ? (^data) : ~(^data);
`else
    if (bad) cfg_in_data = data;
`endif
    @(posedge clk);
    #1;
  endtask

  // Returns 1ns after the last handshake edge; full clean loads are pushed to the scoreboard.
  task automatic runLoad(input logic [CFG_SIZE-1:0] img, input int nwords, input int gap,
                         input bit pulse_start, input int bad_word);
    logic [WORD_WIDTH-1:0] w;
    if (nwords == NUM_WORDS && bad_word < 0) begin
      expq.push_back(img);
      exp_commits++;
    end
    applyStimulus(1'b1, 1'b0, '0, 1'b0);
    checkOutput("ready_after_start", cfg_in_ready, 1);
    checkOutput("busy_after_start", cfg_busy, 1);
    for (int k = 0; k < nwords; k++) begin
      w = img[k*WORD_WIDTH +: WORD_WIDTH];
      applyStimulus(1'b0, 1'b1, w, k == bad_word);
      if (k < nwords - 1) begin
        for (int g = 0; g < gap; g++) begin
          applyStimulus(pulse_start && (k == 2) && (g == 0), 1'b0, '0, 1'b0);
        end
      end
    end
    cfg_in_valid = 1'b0;
  endtask

  task automatic finishCommit(input string tag, input logic [CFG_SIZE-1:0] img);
    checkOutput({tag, "_ready_in_commit"}, cfg_in_ready, 0);
    applyStimulus(1'b0, 1'b0, '0, 1'b0);
    checkOutput({tag, "_done_high"}, cfg_done, 1);
    checkOutput({tag, "_image"}, cfg_out, img);
    applyStimulus(1'b0, 1'b0, '0, 1'b0);
    checkOutput({tag, "_done_low"}, cfg_done, 0);
  endtask

  task automatic resetMidCycle(input string tag);
    #2;
    rst = 1'b1;
    #1;
    checkOutput({tag, "_out"}, cfg_out, 0);
    checkOutput({tag, "_ready"}, cfg_in_ready, 0);
    checkOutput({tag, "_busy"}, cfg_busy, 0);
    checkOutput({tag, "_done"}, cfg_done, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Monitor: every done pulse must match the oldest outstanding image.
  always @(negedge clk) begin
    if (cfg_busy) busy_cycles++;
    if (cfg_done) begin
      done_count++;
      checkOutput("scoreboard_nonempty", 256'(expq.size() > 0), 1);
      if (expq.size() > 0) checkOutput("scoreboard_image", cfg_out, expq.pop_front());
    end
  end

  initial begin
    for (int k = 0; k < NUM_WORDS; k++) begin
      img_a[k*WORD_WIDTH +: WORD_WIDTH] = WORD_WIDTH'(k);
      img_b[k*WORD_WIDTH +: WORD_WIDTH] = 32'hA5A5A5A0 + WORD_WIDTH'(k);
      img_x[k*WORD_WIDTH +: WORD_WIDTH] = $urandom;
      img_y[k*WORD_WIDTH +: WORD_WIDTH] = $urandom;
    end
    rst = 1'b1;
    cfg_start = 1'b0;
    cfg_in_valid = 1'b0;
    cfg_in_data = '0;
`ifdef SB_CFG_PARITY_EN
    cfg_in_parity = 1'b1;
`endif
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    checkOutput("reset_out", cfg_out, 0);
    checkOutput("reset_ready", cfg_in_ready, 0);
    checkOutput("reset_busy", cfg_busy, 0);
    checkOutput("reset_done", cfg_done, 0);
    applyStimulus(1'b0, 1'b1, 32'hDEADBEEF, 1'b0);
    checkOutput("idle_ignores_valid", cfg_busy, 0);

    $display("[TB] back-to-back load");
    runLoad(img_a, NUM_WORDS, 0, 1'b0, -1);
    checkOutput("b2b_out_unchanged", cfg_out, 0);
    checkOutput("b2b_done_not_early", cfg_done, 0);
    finishCommit("b2b", img_a);
    checkOutput("b2b_word0", 256'(cfg_out[31:0]), 0);
    checkOutput("b2b_word7", 256'(cfg_out[255:224]), 7);

    $display("[TB] mid-cycle reset");
    resetMidCycle("rst_async");

    $display("[TB] gaps and ignored start");
    busy_cycles = 0;
    runLoad(img_b, NUM_WORDS, 3, 1'b1, -1);
    checkOutput("gap_out_unchanged", cfg_out, 0);
    finishCommit("gap", img_b);
    checkOutput("gap_busy_cycles", 256'(busy_cycles), 30);

    $display("[TB] reset during load");
    runLoad(img_x, NUM_WORDS, 0, 1'b0, -1);
    finishCommit("pre_rst", img_x);
    runLoad(img_y, 4, 0, 1'b0, -1);
    checkOutput("midload_busy", cfg_busy, 1);
    resetMidCycle("rst_midload");
    runLoad(img_y, NUM_WORDS, 1, 1'b0, -1);
    finishCommit("post_rst", img_y);

    $display("[TB] start on done cycle");
    runLoad(img_a, NUM_WORDS, 0, 1'b0, -1);
    applyStimulus(1'b0, 1'b0, '0, 1'b0);
    checkOutput("sod_first_done", cfg_done, 1);
    checkOutput("sod_first_image", cfg_out, img_a);
    runLoad(img_x, NUM_WORDS, 0, 1'b0, -1);
    checkOutput("sod_old_image_held", cfg_out, img_a);
    finishCommit("sod_second", img_x);

`ifdef SB_CFG_PARITY_EN
    $display("[TB] parity error");
    runLoad(img_x, NUM_WORDS, 0, 1'b0, -1);
    finishCommit("par_pre", img_x);
    runLoad(img_y, 4, 0, 1'b0, 3);
    checkOutput("par_err_set", cfg_err, 1);
    checkOutput("par_ready_low", cfg_in_ready, 0);
    repeat (3) applyStimulus(1'b0, 1'b0, '0, 1'b0);
    checkOutput("par_out_held", cfg_out, img_x);
    checkOutput("par_err_sticky", cfg_err, 1);
    runLoad(img_y, NUM_WORDS, 0, 1'b0, -1);
    checkOutput("par_err_cleared", cfg_err, 0);
    finishCommit("par_post", img_y);
`endif

    for (int i = 0; i < 20 && expq.size() > 0; i++) applyStimulus(1'b0, 1'b0, '0, 1'b0);
    checkOutput("scoreboard_drained", 256'(expq.size()), 0);
    checkOutput("commit_count", 256'(done_count), 256'(exp_commits));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sb_cfg_loader.md
# sb_cfg_loader

Configuration loader sitting directly upstream of the switch box. It accepts configuration words from the fabric configuration bus over a valid/ready handshake and assembles them in a shadow register. It then commits the full image atomically to the `cfg` bus that drives the switch box mux selects, so the routing never sees a partially loaded image. An all-zero image selects the constant-0 input on every switch-box mux, which is the safe reset routing.

## Interface

Parameters:
- `CFG_SIZE`, 256: width of committed configuration image; must be an integer multiple of `WORD_WIDTH`.
- `WORD_WIDTH`, 32: width of one configuration bus word.
- Derived `NUM_WORDS` = `CFG_SIZE/WORD_WIDTH`; word counter width is `$clog2(NUM_WORDS)`, minimum 1.

Ports:
- `clk`, input, 1: single clock; all state is on its rising edge.
- `rst`, input, 1: reset, asynchronous and active-high.
- `cfg_start`, input, 1: single-cycle request to begin loading a new image.
- `cfg_in_valid`, input, 1: `cfg_in_data` is valid.
- `cfg_in_ready`, output, 1: loader accepts a word this cycle.
- `cfg_in_data`, input, WORD_WIDTH: configuration word; word 0 is sent first.
- `cfg_in_parity`, input, 1: odd-parity bit for `cfg_in_data`. Present only with `SB_CFG_PARITY_EN`.
- `cfg_out`, output, CFG_SIZE: committed image; connects to the switch box `cfg`.
- `cfg_busy`, output, 1: high in LOAD and COMMIT.
- `cfg_done`, output, 1: one-cycle pulse, high in the first cycle the new `cfg_out` is visible.
- `cfg_err`, output, 1: sticky parity error flag. Present only with `SB_CFG_PARITY_EN`.

## Operation

State machine: IDLE, LOAD, COMMIT.

- **IDLE**
  - `cfg_in_ready`=0; valid words are ignored.
  - `cfg_start`=1 → LOAD, word counter cleared to 0, `cfg_err` cleared.
- **LOAD**
  - `cfg_in_ready`=1.
  - Handshake = `cfg_in_valid & cfg_in_ready`. On handshake, shadow <= {`cfg_in_data`, shadow[CFG_SIZE-1:WORD_WIDTH]} and the counter increments.
  - Result: word k ends at bits [k*WORD_WIDTH +: WORD_WIDTH].
  - Handshake with counter = NUM_WORDS-1 → COMMIT.
  - `cfg_start` while in LOAD is ignored; the load is not restarted.
- **COMMIT**
  - `cfg_in_ready`=0.
  - At the next edge: `cfg_out` <= shadow, `cfg_done` <= 1, state → IDLE.

Other rules:
- `cfg_out` changes only on the COMMIT edge, all bits simultaneously. It is never modified during LOAD.
- Gaps (valid low) during LOAD are allowed and have unbounded length; the counter holds.
- `cfg_start` in COMMIT is ignored. `cfg_start` in the cycle `cfg_done` is high is accepted normally.
- Reset values: state IDLE, counter 0, shadow 0, `cfg_out` 0, `cfg_in_ready` 0, `cfg_busy` 0, `cfg_done` 0, `cfg_err` 0.
- Reset mid-LOAD or mid-COMMIT: immediate return to the reset values above. `cfg_out` is forced to 0; the old image is not retained.

## Timing

- `cfg_start` sampled at edge T0 → LOAD from T0; `cfg_in_ready`=1 in the cycle after T0.
- Minimum load time with continuous valid: NUM_WORDS cycles of handshake, plus 1 COMMIT cycle.
- Last handshake at edge E → COMMIT during cycle E..E+1. At E+1, `cfg_out` updates and `cfg_done` rises; `cfg_done` falls at E+2.
- `cfg_in_ready`, `cfg_busy` and `cfg_done` are registered-state decodes with no combinational path from inputs. `cfg_in_ready` depends on state only.

## Configuration

`SB_CFG_PARITY_EN`:
- **Defined**
  - Adds `cfg_in_parity` and `cfg_err`.
  - On each handshake, a word whose XOR over {`cfg_in_data`, `cfg_in_parity`} is not 1 (odd parity violated) sets `cfg_err` to 1 and forces state to IDLE at the same edge.
  - The shadow is not updated with the bad word and no commit occurs, so `cfg_out` keeps its previous value.
  - `cfg_err` stays high until the next accepted `cfg_start` or reset.
- **Undefined**
  - Neither port exists; no parity check is performed. Otherwise the behaviour is identical.

## Test plan

(All scenarios use CFG_SIZE=256, WORD_WIDTH=32.)

1. **Reset values**: assert `rst` mid-cycle with no clock edge → `cfg_out`=0, `cfg_in_ready`=0, `cfg_busy`=0, `cfg_done`=0 immediately.
2. **Back-to-back load**: `cfg_start`, then 8 consecutive valid words 0x00000000..0x00000007 → `cfg_out`[31:0]=0, [255:224]=7. `cfg_done` is high for exactly 1 cycle, 1 cycle after the 8th handshake. `cfg_out` is unchanged before that cycle.
3. **Gaps and ignored start**: 8 words 0xA5A5A5A0+k with valid low for 3 cycles between each word, and `cfg_start` pulsed during LOAD → single commit with the correct image, no restart, total busy of 8+21+1 cycles.
4. **Reset mid-LOAD**: commit image X, start a new load, assert `rst` after 4 words → `cfg_out`=0 and state IDLE. A following full load of image Y commits Y.
5. **Parity error** (`SB_CFG_PARITY_EN` defined): after committing image X, send a new load with a bad parity bit on word 3 → `cfg_err`=1, `cfg_in_ready`=0 next cycle, `cfg_out` stays X, no `cfg_done`. A following `cfg_start` clears `cfg_err`.
6. **Start on done cycle**: assert `cfg_start` in the cycle `cfg_done` is high → second load begins and commits correctly; first image is visible until the second commit.
